dual_port_mem_responder: RTL and testbench
==========================================

// Module: dual_port_mem_responder
// PURPOSE
//   Responder end of the two-port CPU memory interface (port A / port B). Accepts
//   read/write requests, waits a fixed latency, pulses resp, returns rdata. Both
//   ports share one word-addressed backing array. Serves as the memory behind the
//   CPU in full-chip simulation and as the model future caches are checked against.
// PARAMETERS
//   ADDR_BITS  10  word-index bits of backing array (2**ADDR_BITS 32-bit words)
//   LATENCY    2   cycles from request acceptance to resp; legal range 1..15
// PORTS
//   clk                  in   1   single clock, all state on rising edge
//   rst                  in   1   synchronous, active-high reset
//   mem_read_a/_b        in   1   read request, held high until resp
//   mem_write_a/_b       in   1   write request, held high until resp
//   mem_byte_enable_a/_b in   4   write byte lanes; bit i -> data[8i+7:8i]
//   mem_address_a/_b     in   32  byte address; word index = addr[ADDR_BITS+1:2]
//   mem_wdata_a/_b       in   32  write data
//   mem_resp_a/_b        out  1   one-cycle completion pulse
//   mem_rdata_a/_b       out  32  read data, valid only while resp high
// BEHAVIOUR
//   Per-port FSM (identical and independent): IDLE -> WAIT -> RESP -> IDLE.
//   - IDLE: if read|write high, latch op, word index, wdata, byte_enable; cnt<=LATENCY-1;
//     go RESP if LATENCY==1, else WAIT.
//   - WAIT: cnt decrements each cycle; when cnt==1, go RESP next cycle.
//   - RESP: resp=1 for exactly 1 cycle; go IDLE. Request first high in cycle T ->
//     resp high in cycle T+LATENCY.
//   - Request inputs ignored in WAIT/RESP; address/data changes after accept have no effect.
//   - Request still high in the IDLE cycle after RESP = new access (back-to-back allowed,
//     throughput one access per LATENCY+1 cycles per port).
//   - read and write both high: write wins, read ignored, rdata=0.
//   - Reads: rdata = array[latched index] during RESP; 0 in every other cycle.
//   - Writes: enabled bytes committed at the clock edge ending RESP; be=4'b0000 still
//     completes with resp, array unchanged.
//   - Address bits above ADDR_BITS+1 ignored (aliasing wrap); bits [1:0] ignored.
//   - Cross-port ordering: a write committed at edge E is visible to any read whose
//     RESP cycle follows E. Read RESP in same cycle as other port's write RESP on same
//     word returns OLD data.
//   - Both ports commit writes to same word same edge: A's bytes applied first, then B's;
//     B wins on overlapping lanes, non-overlapping lanes from each are kept.
//   - Reset: both FSMs IDLE, cnt=0, resp_a/b=0, rdata_a/b=0. Array contents not cleared.
//     Reset during WAIT/RESP aborts access: no resp, no write commit.
// CONFIGURATION
//   MEM_COLLISION_DETECT_EN defined: adds output mem_collision (1 bit, reset 0), pulsed
//     high for the one cycle both ports are in RESP with equal word index and at least
//     one is a write; adds 16-bit saturating counter collision_count (out, reset 0)
//     incremented on each such pulse. Array behaviour unchanged.
//   Not defined: ports and counter absent; same-word resolution rule above still applies.
// TESTING
//   - LATENCY=2: A write addr 0x10 wdata 0xDEADBEEF be 4'hF at T -> resp_a at T+2; then A
//     read 0x10 -> rdata_a=0xDEADBEEF with resp_a exactly 2 cycles after request.
//   - Byte lanes: word=0x11223344, write be=4'b0101 wdata 0xAABBCCDD -> read 0x11BB33DD.
//   - Same-edge collision: A writes 0xFFFF0000 be 4'b1100, B writes 0x0000FFFF be 4'b0110,
//     same word -> read back B bytes [23:8], A byte [31:24], old byte [7:0].
//   - Alias: ADDR_BITS=10, write 0x1004=0x5A5A5A5A, read 0x0004 -> 0x5A5A5A5A.
//   - rst pulsed in WAIT of a write to 0x20 (old 0x0) -> no resp, read 0x20 returns 0x0.
//   - LATENCY=1 back-to-back reads held high 4 cycles on B -> resp_b high cycles 1 and 3;
//     with MEM_COLLISION_DETECT_EN, simultaneous A write/B read same word -> mem_collision
//     1 cycle, collision_count=1, B gets old data.

Source files
------------

// File: rtl/dual_port_mem_responder.sv
// Two-port memory responder: fixed-latency read/write over one shared word array.
// Optional MEM_COLLISION_DETECT_EN adds a same-word RESP collision pulse and saturating counter.
module dual_port_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_a,
  input  logic        mem_write_a,
  input  logic [3:0]  mem_byte_enable_a,
  input  logic [31:0] mem_address_a,
  input  logic [31:0] mem_wdata_a,
  input  logic        mem_read_b,
  input  logic        mem_write_b,
  input  logic [3:0]  mem_byte_enable_b,
  input  logic [31:0] mem_address_b,
  input  logic [31:0] mem_wdata_b,
  output logic        mem_resp_a,
  output logic [31:0] mem_rdata_a,
  output logic        mem_resp_b,
  output logic [31:0] mem_rdata_b
`ifdef MEM_COLLISION_DETECT_EN
  ,
  output logic        mem_collision,
  output logic [15:0] collision_count
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] r_mem [0:(1<<ADDR_BITS)-1];

  logic                 w_req_rd   [2];
  logic                 w_req_wr   [2];
  logic [3:0]           w_req_be   [2];
  logic [31:0]          w_req_addr [2];
  logic [31:0]          w_req_wd   [2];
  logic                 w_resp     [2];
  logic [31:0]          w_rdata    [2];
  logic                 w_commit   [2];
  logic                 w_is_write [2];
  logic [ADDR_BITS-1:0] w_idx      [2];
  logic [31:0]          w_wdata    [2];
  logic [3:0]           w_be       [2];

  assign w_req_rd[0]   = mem_read_a;
  assign w_req_wr[0]   = mem_write_a;
  assign w_req_be[0]   = mem_byte_enable_a;
  assign w_req_addr[0] = mem_address_a;
  assign w_req_wd[0]   = mem_wdata_a;
  assign w_req_rd[1]   = mem_read_b;
  assign w_req_wr[1]   = mem_write_b;
  assign w_req_be[1]   = mem_byte_enable_b;
  assign w_req_addr[1] = mem_address_b;
  assign w_req_wd[1]   = mem_wdata_b;

  assign mem_resp_a  = w_resp[0];
  assign mem_rdata_a = w_rdata[0];
  assign mem_resp_b  = w_resp[1];
  assign mem_rdata_b = w_rdata[1];

  logic w_unused_addr;
  assign w_unused_addr = ^{mem_address_a[31:ADDR_BITS+2], mem_address_a[1:0],
                           mem_address_b[31:ADDR_BITS+2], mem_address_b[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      state_t               r_state;
      state_t               w_state_next;
      logic [3:0]           r_cnt;
      logic                 r_is_write;
      logic [ADDR_BITS-1:0] r_idx;
      logic [31:0]          r_wdata;
      logic [3:0]           r_be;
      logic                 w_req;
      logic                 w_resp_p;

      assign w_req = w_req_rd[gi] | w_req_wr[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          if (r_state == S_IDLE && w_req)
            r_cnt <= CNT_INIT;
          else if (r_state == S_WAIT)
            r_cnt <= r_cnt - 4'd1;
        end
      end

      // Request fields are captured once at acceptance; later input changes are ignored.
      always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req) begin
          r_is_write <= w_req_wr[gi];
          r_idx      <= w_req_addr[gi][ADDR_BITS+1:2];
          r_wdata    <= w_req_wd[gi];
          r_be       <= w_req_be[gi];
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_resp_p     = 1'b0;
        case (r_state)
          S_IDLE:  if (w_req) w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
          S_WAIT:  if (r_cnt == 4'd1) w_state_next = S_RESP;
          S_RESP: begin
            w_state_next = S_IDLE;
            w_resp_p     = ~rst;
          end
          default: w_state_next = S_IDLE;
        endcase
      end

      assign w_resp[gi]     = w_resp_p;
      assign w_commit[gi]   = w_resp_p & r_is_write;
      assign w_is_write[gi] = r_is_write;
      assign w_idx[gi]      = r_idx;
      assign w_wdata[gi]    = r_wdata;
      assign w_be[gi]       = r_be;
      // Unregistered read so a write committed on the edge starting this RESP is visible.
      assign w_rdata[gi]    = (w_resp_p && !r_is_write) ? r_mem[r_idx] : 32'h0;
    end
  endgenerate

  // Port B is applied after port A so it wins overlapping lanes on the same word.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (w_commit[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[p][b])
            r_mem[w_idx[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
        end
      end
    end
  end

`ifdef MEM_COLLISION_DETECT_EN
  logic        w_collision;
  logic [15:0] r_collision_count;

  assign w_collision = w_resp[0] & w_resp[1] & (w_idx[0] == w_idx[1]) &
                       (w_is_write[0] | w_is_write[1]);

  always_ff @(posedge clk) begin
    if (rst)
      r_collision_count <= '0;
    else if (w_collision && r_collision_count != 16'hFFFF)
      r_collision_count <= r_collision_count + 16'd1;
  end

  assign mem_collision   = w_collision;
  assign collision_count = r_collision_count;
`else
  logic w_unused_is_write;
  assign w_unused_is_write = w_is_write[0] ^ w_is_write[1];
`endif

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Scoreboard bench for dual_port_mem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
// Collision output checks are compiled in when MEM_COLLISION_DETECT_EN is defined.
module tb_dual_port_mem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [3:0]  be_a, be_b;
  logic [31:0] addr_a, addr_b, wd_a, wd_b;
  logic        resp_a, resp_b;
  logic [31:0] rdata_a, rdata_b;

  logic        l_rd_a, l_wr_a, l_rd_b, l_wr_b;
  logic [3:0]  l_be_a, l_be_b;
  logic [31:0] l_addr_a, l_addr_b, l_wd_a, l_wd_b;
  logic        l_resp_a, l_resp_b;
  logic [31:0] l_rdata_a, l_rdata_b;

`ifdef MEM_COLLISION_DETECT_EN
  logic        coll, l_coll;
  logic [15:0] ccount, l_ccount;
`endif

  dual_port_mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .mem_read_a(rd_a), .mem_write_a(wr_a), .mem_byte_enable_a(be_a),
    .mem_address_a(addr_a), .mem_wdata_a(wd_a),
    .mem_read_b(rd_b), .mem_write_b(wr_b), .mem_byte_enable_b(be_b),
    .mem_address_b(addr_b), .mem_wdata_b(wd_b),
    .mem_resp_a(resp_a), .mem_rdata_a(rdata_a),
    .mem_resp_b(resp_b), .mem_rdata_b(rdata_b)
`ifdef MEM_COLLISION_DETECT_EN
    , .mem_collision(coll), .collision_count(ccount)
`endif
  );

  dual_port_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_read_a(l_rd_a), .mem_write_a(l_wr_a), .mem_byte_enable_a(l_be_a),
    .mem_address_a(l_addr_a), .mem_wdata_a(l_wd_a),
    .mem_read_b(l_rd_b), .mem_write_b(l_wr_b), .mem_byte_enable_b(l_be_b),
    .mem_address_b(l_addr_b), .mem_wdata_b(l_wd_b),
    .mem_resp_a(l_resp_a), .mem_rdata_a(l_rdata_a),
    .mem_resp_b(l_resp_b), .mem_rdata_b(l_rdata_b)
`ifdef MEM_COLLISION_DETECT_EN
    , .mem_collision(l_coll), .collision_count(l_ccount)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  // Call #1 after a rising edge: the request is first high in cycle 'cyc'.
  task automatic start_req(input bit port, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_rd);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.data = exp_rd;
    if (!port) begin
      rd_a = rd; wr_a = wr; addr_a = addr; wd_a = wd; be_a = be;
      q_a.push_back(e);
    end else begin
      rd_b = rd; wr_b = wr; addr_b = addr; wd_b = wd; be_b = be;
      q_b.push_back(e);
    end
  endtask

  task automatic wait_resp(input bit port, input string name, input bit hold);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = port ? resp_b : resp_a;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: resp timeout, got 0 required 1", name);
    end else if ((port ? q_b.size() : q_a.size()) == 0) begin
      bad++;
      $display("FAIL %s: unexpected resp, got 1 required 0", name);
    end else begin
      e = port ? q_b.pop_front() : q_a.pop_front();
      if (cyc !== e.cyc) begin
        bad++;
        $display("FAIL %s_latency: resp cycle got %0d required %0d", name, cyc, e.cyc);
      end
      total++;
      if ((port ? rdata_b : rdata_a) !== e.data) begin
        bad++;
        $display("FAIL %s_rdata: got %h required %h", name, port ? rdata_b : rdata_a, e.data);
      end
      $display("txn %s port=%0d cyc=%0d rdata=%h", name, port, cyc, port ? rdata_b : rdata_a);
    end
    if (!hold) begin
      if (!port) begin rd_a = 0; wr_a = 0; end
      else begin rd_b = 0; wr_b = 0; end
    end
  endtask

  task automatic access(input bit port, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_rd,
                        input string name);
    @(posedge clk); #1;
    start_req(port, rd, wr, addr, wd, be, exp_rd);
    wait_resp(port, name, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({resp_a, resp_b, l_resp_a, l_resp_b} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_resp: got %b required 0000", {resp_a, resp_b, l_resp_a, l_resp_b});
    end
    total++;
    if ({rdata_a, rdata_b} !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h required 0", {rdata_a, rdata_b});
    end
`ifdef MEM_COLLISION_DETECT_EN
    total++;
    if ({coll, ccount} !== 17'h0) begin
      bad++;
      $display("FAIL reset_collision: got %h required 0", {coll, ccount});
    end
`endif
  endtask

  task automatic test_basic();
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "wr_10");
    access(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, "rd_10");
  endtask

  task automatic test_byte_lanes();
    access(0, 0, 1, 32'h30, 32'h11223344, 4'hF, 32'h0, "wr_30_full");
    access(1, 0, 1, 32'h30, 32'hAABBCCDD, 4'b0101, 32'h0, "wr_30_lanes");
    access(1, 1, 0, 32'h30, 32'h0, 4'h0, 32'h11BB33DD, "rd_30");
    access(0, 0, 1, 32'h30, 32'hFFFFFFFF, 4'b0000, 32'h0, "wr_30_be0");
    access(0, 1, 0, 32'h30, 32'h0, 4'h0, 32'h11BB33DD, "rd_30_be0");
  endtask

  task automatic test_same_edge();
    access(0, 0, 1, 32'h50, 32'h01020304, 4'hF, 32'h0, "wr_50_init");
    @(posedge clk); #1;
    start_req(0, 0, 1, 32'h50, 32'hFFFF0000, 4'b1100, 32'h0);
    start_req(1, 0, 1, 32'h50, 32'h0000FFFF, 4'b0110, 32'h0);
    fork
      wait_resp(0, "coll_wr_a", 1'b0);
      wait_resp(1, "coll_wr_b", 1'b0);
    join
    access(0, 1, 0, 32'h50, 32'h0, 4'h0, 32'hFF00FF04, "rd_50_merge");
    // Read RESP coinciding with the other port's write RESP sees old data.
    @(posedge clk); #1;
    start_req(0, 0, 1, 32'h50, 32'h77777777, 4'hF, 32'h0);
    start_req(1, 1, 0, 32'h50, 32'h0, 4'h0, 32'hFF00FF04);
    fork
      wait_resp(0, "ord_wr_a", 1'b0);
      wait_resp(1, "ord_rd_b", 1'b0);
    join
    access(1, 1, 0, 32'h50, 32'h0, 4'h0, 32'h77777777, "rd_50_new");
`ifdef MEM_COLLISION_DETECT_EN
    @(negedge clk);
    total++;
    if (ccount !== 16'd2) begin
      bad++;
      $display("FAIL coll_count_lat2: got %0d required 2", ccount);
    end
`endif
  endtask

  task automatic test_alias_and_conflict();
    access(0, 0, 1, 32'h1004, 32'h5A5A5A5A, 4'hF, 32'h0, "wr_1004");
    access(1, 1, 0, 32'h0004, 32'h0, 4'h0, 32'h5A5A5A5A, "rd_0004");
    access(1, 1, 0, 32'h0007, 32'h0, 4'h0, 32'h5A5A5A5A, "rd_0007");
    access(0, 1, 1, 32'h70, 32'h13572468, 4'hF, 32'h0, "rdwr_70");
    access(0, 1, 0, 32'h70, 32'h0, 4'h0, 32'h13572468, "rd_70");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    start_req(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    wait_resp(0, "b2b_first", 1'b1);
    @(posedge clk); #1;
    start_req(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    wait_resp(0, "b2b_second", 1'b0);
  endtask

  task automatic test_reset_abort();
    int resp_seen;
    access(0, 0, 1, 32'h20, 32'h0, 4'hF, 32'h0, "wr_20_init");
    resp_seen = 0;
    @(posedge clk); #1;
    wr_a = 1; rd_a = 0; addr_a = 32'h20; wd_a = 32'h99999999; be_a = 4'hF;
    @(negedge clk);
    resp_seen += int'(resp_a);
    @(posedge clk); #1;
    rst = 1; wr_a = 0;
    @(negedge clk);
    resp_seen += int'(resp_a);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      resp_seen += int'(resp_a);
    end
    total++;
    if (resp_seen != 0) begin
      bad++;
      $display("FAIL abort_resp: got %0d resp cycles required 0", resp_seen);
    end
    access(1, 1, 0, 32'h20, 32'h0, 4'h0, 32'h0, "rd_20_abort");
  endtask

  task automatic test_latency1();
    logic [3:0] pat;
    @(posedge clk); #1;
    l_wr_a = 1; l_addr_a = 32'h40; l_wd_a = 32'h12345678; l_be_a = 4'hF;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (l_resp_a !== 1'b1) begin
      bad++;
      $display("FAIL lat1_wr_resp: got %b required 1", l_resp_a);
    end
    l_wr_a = 0;
    @(posedge clk); #1;
    l_rd_b = 1; l_addr_b = 32'h40;
    pat = 4'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = l_resp_b;
      if (l_resp_b) begin
        total++;
        if (l_rdata_b !== 32'h12345678) begin
          bad++;
          $display("FAIL lat1_b2b_rdata: got %h required 12345678", l_rdata_b);
        end
      end
    end
    l_rd_b = 0;
    total++;
    if (pat !== 4'b1010) begin
      bad++;
      $display("FAIL lat1_b2b_pattern: got %b required 1010", pat);
    end
    $display("txn lat1_b2b pattern=%b", pat);
    @(posedge clk); #1;
    l_wr_a = 1; l_addr_a = 32'h40; l_wd_a = 32'hCAFEF00D; l_be_a = 4'hF;
    l_rd_b = 1; l_addr_b = 32'h40;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({l_resp_b, l_rdata_b} !== {1'b1, 32'h12345678}) begin
      bad++;
      $display("FAIL lat1_coll_old: got %b/%h required 1/12345678", l_resp_b, l_rdata_b);
    end
`ifdef MEM_COLLISION_DETECT_EN
    total++;
    if (l_coll !== 1'b1) begin
      bad++;
      $display("FAIL lat1_coll_pulse: got %b required 1", l_coll);
    end
`endif
    l_wr_a = 0; l_rd_b = 0;
    @(negedge clk);
`ifdef MEM_COLLISION_DETECT_EN
    total++;
    if ({l_coll, l_ccount} !== {1'b0, 16'd1}) begin
      bad++;
      $display("FAIL lat1_coll_count: got %b/%0d required 0/1", l_coll, l_ccount);
    end
`endif
    @(posedge clk); #1;
    l_rd_b = 1; l_addr_b = 32'h40;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({l_resp_b, l_rdata_b} !== {1'b1, 32'hCAFEF00D}) begin
      bad++;
      $display("FAIL lat1_rd_new: got %b/%h required 1/cafef00d", l_resp_b, l_rdata_b);
    end
    l_rd_b = 0;
  endtask

  initial begin
    rst = 1;
    rd_a = 0; wr_a = 0; be_a = 0; addr_a = 0; wd_a = 0;
    rd_b = 0; wr_b = 0; be_b = 0; addr_b = 0; wd_b = 0;
    l_rd_a = 0; l_wr_a = 0; l_be_a = 0; l_addr_a = 0; l_wd_a = 0;
    l_rd_b = 0; l_wr_b = 0; l_be_b = 0; l_addr_b = 0; l_wd_b = 0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_same_edge();
    test_alias_and_conflict();
    test_back_to_back();
    test_reset_abort();
    test_latency1();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
